// File: rtl/rca_seq_pkg.sv
// rtl/rca_seq_pkg.sv - shared types and helpers for the nibble-serial adder
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam int NIBBLE_W = 4;

    function automatic int nibbles(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/rca_4bit.sv
// rtl/rca_4bit.sv - 4-bit ripple-carry adder
module rca_4bit (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic carry;

    always_comb begin
        s     = '0;
        carry = c_in;
        for (int i = 0; i < 4; i++) begin
            s[i]  = x[i] ^ y[i] ^ carry;
            carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        c_out = carry;
    end

endmodule

// File: rtl/rca_seq_adder.sv
// rtl/rca_seq_adder.sv - multi-cycle add/subtract sequencer over one shared 4-bit adder
module rca_seq_adder
    import rca_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int N     = nibbles(WIDTH);
    localparam int IDX_W = $clog2(N);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("rca_seq_adder: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    seq_state_t          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_eff_q, b_eff_d;
    logic [WIDTH-1:0]    sum_q, sum_d;
    logic                cin_q, cin_d;
    logic                c_out_q, c_out_d;

    logic [WIDTH-1:0]    a_sh, b_sh;
    logic [NIBBLE_W-1:0] nib_s;
    logic                nib_c;

    // Shift the selected nibble down to bit 0 so the adder always sees [3:0].
    assign a_sh = a_q >> (NIBBLE_W * int'(idx_q));
    assign b_sh = b_eff_q >> (NIBBLE_W * int'(idx_q));

    rca_4bit u_rca (
        .x     (a_sh[NIBBLE_W-1:0]),
        .y     (b_sh[NIBBLE_W-1:0]),
        .c_in  (cin_q),
        .s     (nib_s),
        .c_out (nib_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_eff_q <= '0;
            sum_q   <= '0;
            cin_q   <= 1'b0;
            c_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_eff_q <= b_eff_d;
            sum_q   <= sum_d;
            cin_q   <= cin_d;
            c_out_q <= c_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_eff_d = b_eff_q;
        sum_d   = sum_q;
        cin_d   = cin_q;
        c_out_d = c_out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_eff_d = sub ? ~b : b;
                    cin_d   = sub;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[NIBBLE_W * int'(idx_q) +: NIBBLE_W] = nib_s;
                cin_d = nib_c;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N - 1)) begin
                    c_out_d = nib_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        c_out     = c_out_q;
        overflow  = (state_q == DONE)
                 && (a_q[WIDTH-1] == b_eff_q[WIDTH-1])
                 && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
    end

endmodule

// File: tb/tb_rca_seq_adder.sv
// tb/tb_rca_seq_adder.sv - directed self-checking bench for rca_seq_adder
module tb_rca_seq_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    rca_seq_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accepts one operation and waits (bounded) for out_valid, checking latency.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tsub, input bit scramble);
        int lat;
        @(negedge clk);
        a = ta; b = tb_v; sub = tsub; in_valid = 1'b1;
        check("in_ready_before_accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (scramble) begin
                a   = 16'($urandom);
                b   = 16'($urandom);
                sub = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 4);
    endtask

    task automatic check_result(input string tag, input logic [15:0] es,
                                input logic ec, input logic eo);
        check({tag, "_sum"}, sum, es);
        check({tag, "_c_out"}, c_out, ec);
        check({tag, "_ovf"}, overflow, eo);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_out_valid_low"}, out_valid, 0);
        check({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_c_out", c_out, 0);
        check("rst_ovf", overflow, 0);

        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        check_result("add", 16'h2233, 1'b0, 1'b0);
        release_result("add");

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check_result("wrap", 16'h0000, 1'b1, 1'b0);
        release_result("wrap");

        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        check_result("pos_ovf", 16'h8000, 1'b0, 1'b1);
        release_result("pos_ovf");

        run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
        check_result("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
        release_result("sub_ovf");

        run_op(16'h0000, 16'h0001, 1'b1, 1'b0);
        check_result("sub_borrow", 16'hFFFF, 1'b0, 1'b0);
        release_result("sub_borrow");

        // Operands churn every RUN cycle; result must reflect the latched values.
        run_op(16'h4321, 16'h1234, 1'b1, 1'b1);
        check_result("stable_in", 16'h30ED, 1'b1, 1'b0);
        release_result("stable_in");

        // Back-pressure with a competing request in DONE.
        run_op(16'hA5A5, 16'h5A5A, 1'b0, 1'b0);
        check_result("bp", 16'hFFFF, 1'b0, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 16'h1111 * 16'(i + 1);
            b = 16'h0101 * 16'(i + 3);
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_sum", sum, 16'hFFFF);
            check("bp_c_out", c_out, 0);
            check("bp_ovf", overflow, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_release_idle", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        @(negedge clk);
        check("bp_no_accept", in_ready, 1);
        check("bp_sum_held", sum, 16'hFFFF);

        // Reset during the second RUN cycle.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_in_ready", in_ready, 1);
        repeat (6) @(negedge clk);
        check("abort_no_result", out_valid, 0);

        run_op(16'h0001, 16'h0002, 1'b0, 1'b0);
        check_result("post_abort", 16'h0003, 1'b0, 1'b0);
        release_result("post_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
